// File: rtl/serial_ram_loader.sv
// Serial program loader: parses SYNC/ADDR/LEN/payload/CSUM packets from the UART
// byte stream, requests the Z80 bus and writes the payload into main memory.
module serial_ram_loader #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 2500000,
   parameter logic [7:0]  SYNC       = 8'hA5
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        busak_n,
   output logic        busrq_n,
   output logic        mem_owner,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_we,
   output logic        busy,
   output logic        done,
   output logic        err_csum,
   output logic        err_ovf,
   output logic        err_tmo
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_HDR    = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_CSUM   = 3'd3;
   localparam logic [2:0] S_FINISH = 3'd4;

   logic [2:0]    state, state_nxt;
   logic [1:0]    hdr_cnt, hdr_cnt_nxt;
   logic [15:0]   ptr, ptr_nxt;
   logic [15:0]   remaining, remaining_nxt;
   logic [7:0]    sum, sum_nxt;
   logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;
   logic [AW-1:0] rd_ptr, rd_ptr_nxt, wr_ptr, wr_ptr_nxt;
   logic [CW-1:0] count, count_nxt;
   logic          busrq_n_nxt, mem_owner_nxt, mem_we_nxt, busy_nxt, done_nxt;
   logic [15:0]   mem_addr_nxt;
   logic [7:0]    mem_wdata_nxt;
   logic          err_csum_nxt, err_ovf_nxt, err_tmo_nxt;

   logic [7:0]    fifo_mem [FIFO_DEPTH];

   logic active_c, full_c, pop_req_c, ovf_c, tmo_c, abort_c, push_c, pop_c;

   // A pop in the same cycle frees a slot, so a push to a full FIFO is then legal
   assign active_c  = (state == S_HDR) || (state == S_DATA) || (state == S_CSUM);
   assign full_c    = (count == CW'(FIFO_DEPTH));
   assign pop_req_c = mem_owner && !busak_n && (count != '0);
   assign ovf_c     = (state == S_DATA) && rx_valid && full_c && !pop_req_c;
   assign tmo_c     = active_c && !rx_valid && (tmo_cnt >= TW'(TIMEOUT - 1));
   assign abort_c   = ovf_c || tmo_c;
   assign push_c    = (state == S_DATA) && rx_valid && !ovf_c;
   assign pop_c     = pop_req_c && !abort_c;

   // Next-state and registered-output logic
   always_comb begin
      state_nxt     = state;
      hdr_cnt_nxt   = hdr_cnt;
      ptr_nxt       = ptr;
      remaining_nxt = remaining;
      sum_nxt       = sum;
      tmo_cnt_nxt   = '0;
      rd_ptr_nxt    = rd_ptr;
      wr_ptr_nxt    = wr_ptr;
      count_nxt     = count;
      busrq_n_nxt   = busrq_n;
      mem_owner_nxt = !busrq_n && !busak_n;
      mem_addr_nxt  = mem_addr;
      mem_wdata_nxt = mem_wdata;
      mem_we_nxt    = 1'b0;
      done_nxt      = 1'b0;
      err_csum_nxt  = err_csum;
      err_ovf_nxt   = err_ovf;
      err_tmo_nxt   = err_tmo;

      if (active_c && !rx_valid) tmo_cnt_nxt = tmo_cnt + TW'(1);

      case (state)
         S_IDLE: begin
            if (rx_valid && (rx_data == SYNC)) begin
               state_nxt    = S_HDR;
               hdr_cnt_nxt  = 2'd0;
               sum_nxt      = 8'd0;
               err_csum_nxt = 1'b0;
               err_ovf_nxt  = 1'b0;
               err_tmo_nxt  = 1'b0;
            end
         end
         S_HDR: begin
            if (rx_valid) begin
               hdr_cnt_nxt = hdr_cnt + 2'd1;
               case (hdr_cnt)
                  2'd0: ptr_nxt[15:8] = rx_data;
                  2'd1: ptr_nxt[7:0]  = rx_data;
                  2'd2: remaining_nxt[15:8] = rx_data;
                  default: begin
                     remaining_nxt[7:0] = rx_data;
                     state_nxt = ({remaining[15:8], rx_data} != 16'd0) ? S_DATA : S_CSUM;
                  end
               endcase
            end
         end
         S_DATA: begin
            busrq_n_nxt = 1'b0;
            if (push_c) begin
               sum_nxt       = sum + rx_data;
               remaining_nxt = remaining - 16'd1;
               if (remaining == 16'd1) state_nxt = S_CSUM;
            end
         end
         S_CSUM: begin
            if (rx_valid) begin
               if (rx_data != sum) err_csum_nxt = 1'b1;
               state_nxt = S_FINISH;
            end
         end
         S_FINISH: begin
            if (count == '0) begin
               done_nxt    = 1'b1;
               busrq_n_nxt = 1'b1;
               state_nxt   = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      if (push_c) wr_ptr_nxt = wr_ptr + AW'(1);

      // Write engine: one FIFO byte per owned cycle at the auto-incrementing pointer
      if (pop_c) begin
         mem_we_nxt    = 1'b1;
         mem_addr_nxt  = ptr;
         mem_wdata_nxt = fifo_mem[rd_ptr];
         ptr_nxt       = ptr + 16'd1;
         rd_ptr_nxt    = rd_ptr + AW'(1);
      end

      if (push_c && !pop_c)      count_nxt = count + CW'(1);
      else if (!push_c && pop_c) count_nxt = count - CW'(1);

      if (abort_c) begin
         state_nxt   = S_IDLE;
         busrq_n_nxt = 1'b1;
         count_nxt   = '0;
         rd_ptr_nxt  = wr_ptr;
         wr_ptr_nxt  = wr_ptr;
         if (ovf_c) err_ovf_nxt = 1'b1;
         if (tmo_c) err_tmo_nxt = 1'b1;
      end

      busy_nxt = (state_nxt != S_IDLE) || (count_nxt != '0);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= S_IDLE;
         hdr_cnt   <= 2'd0;
         ptr       <= 16'd0;
         remaining <= 16'd0;
         sum       <= 8'd0;
         tmo_cnt   <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         busrq_n   <= 1'b1;
         mem_owner <= 1'b0;
         mem_addr  <= 16'd0;
         mem_wdata <= 8'd0;
         mem_we    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err_csum  <= 1'b0;
         err_ovf   <= 1'b0;
         err_tmo   <= 1'b0;
      end else begin
         state     <= state_nxt;
         hdr_cnt   <= hdr_cnt_nxt;
         ptr       <= ptr_nxt;
         remaining <= remaining_nxt;
         sum       <= sum_nxt;
         tmo_cnt   <= tmo_cnt_nxt;
         rd_ptr    <= rd_ptr_nxt;
         wr_ptr    <= wr_ptr_nxt;
         count     <= count_nxt;
         busrq_n   <= busrq_n_nxt;
         mem_owner <= mem_owner_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_wdata <= mem_wdata_nxt;
         mem_we    <= mem_we_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         err_csum  <= err_csum_nxt;
         err_ovf   <= err_ovf_nxt;
         err_tmo   <= err_tmo_nxt;
      end
   end

   // Payload storage; contents are don't-care while empty, so no reset
   always_ff @(posedge clk) begin
      if (push_c) fifo_mem[wr_ptr] <= rx_data;
   end

endmodule
